// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM bank controller.
//   SRAM_ADDR_W / SRAM_DATA_W : geometry of one thinpad SRAM bank (1M x 32)
//   sram_state_t              : controller sequencing states
//   max2                      : helper used to size the shared wait counter
package sram_controller_pkg;
  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} sram_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sram_controller_if.sv
// CPU-side request/response port of the SRAM controller.
//   master : request producer (core load/store path)
//   slave  : the controller
//   req_valid/req_ready handshake, req_we/addr/be/wdata payload,
//   rsp_valid one-cycle pulse with rsp_rdata (no backpressure).
interface sram_controller_if
  import sram_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [3:0]             req_be;
  logic [SRAM_DATA_W-1:0] req_wdata;
  logic                   rsp_valid;
  logic [SRAM_DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_controller.sv
// Bridges the CPU request port to one 32-bit asynchronous SRAM bank.
// Fixed-length read (READ_WAIT cycles of CE/OE low) and write
// (setup, WRITE_WAIT cycles of WE low, hold) sequences. Every SRAM pin and
// the data drive enable come straight from flops, so strobes are glitch free.
//   clk_50M, reset_n : clock, async active-low reset
//   bus              : request/response port (slave side)
//   ram_data         : SRAM data bus (tristate)
//   ram_addr         : SRAM word address
//   ram_be_n         : byte enables, active low
//   ram_ce_n/oe_n/we_n : SRAM strobes, active low
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                   clk_50M,
  input  logic                   reset_n,
  sram_controller_if.slave       bus,
  inout  wire  [SRAM_DATA_W-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [3:0]             ram_be_n,
  output logic                   ram_ce_n,
  output logic                   ram_oe_n,
  output logic                   ram_we_n
);
  localparam int CW = $clog2(max2(READ_WAIT, WRITE_WAIT) + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_WAIT - 1);

  sram_state_t            state, next_state;
  logic [CW-1:0]          cnt, cnt_next;
  logic                   accept;
  logic                   drive_en;
  logic [SRAM_DATA_W-1:0] wdata;

  // Write data is only put on the bus while a write sequence owns it.
  assign ram_data = drive_en ? wdata : {SRAM_DATA_W{1'bz}};

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept = 1'b1;
          if (bus.req_we) begin
            next_state = WR_SETUP;
          end else begin
            next_state = RD;
            cnt_next   = RD_LOAD;
          end
        end
      end
      RD: begin
        if (cnt == '0) next_state = IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
      WR_SETUP: begin
        next_state = WR_PULSE;
        cnt_next   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt == '0) next_state = WR_HOLD;
        else           cnt_next   = cnt - 1'b1;
      end
      WR_HOLD: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      ram_addr      <= '0;
      ram_be_n      <= 4'hF;
      ram_ce_n      <= 1'b1;
      ram_oe_n      <= 1'b1;
      ram_we_n      <= 1'b1;
      drive_en      <= 1'b0;
      wdata         <= '0;
    end else begin
      state         <= next_state;
      cnt           <= cnt_next;
      // Pin values are derived from the state being entered, so they
      // change on the same edge as the state register.
      bus.req_ready <= (next_state == IDLE);
      bus.rsp_valid <= ((state == RD) || (state == WR_HOLD)) && (next_state == IDLE);
      ram_ce_n      <= (next_state == IDLE);
      ram_oe_n      <= (next_state != RD);
      ram_we_n      <= (next_state != WR_PULSE);
      drive_en      <= (next_state == WR_SETUP) || (next_state == WR_PULSE) ||
                       (next_state == WR_HOLD);
      if (accept) begin
        ram_addr <= bus.req_addr;
        wdata    <= bus.req_wdata;
      end
      if (next_state == IDLE) ram_be_n <= 4'hF;
      else if (accept)        ram_be_n <= ~bus.req_be;
      if ((state == RD) && (next_state == IDLE)) bus.rsp_rdata <= ram_data;
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural async SRAM.
// Stimulus pushes expected responses into a queue; a monitor pops and
// compares data, latency and write-pulse width whenever rsp_valid pulses.
module tb_sram_controller;
  localparam int READ_WAIT  = 2;
  localparam int WRITE_WAIT = 2;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          acc;
    logic        wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  wire  [31:0] ram_data;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  sram_controller_if #(.ADDR_WIDTH(20)) bus();

  sram_controller #(.ADDR_WIDTH(20), .READ_WAIT(READ_WAIT), .WRITE_WAIT(WRITE_WAIT)) dut (
    .clk_50M (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .ram_data(ram_data),
    .ram_addr(ram_addr),
    .ram_be_n(ram_be_n),
    .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n)
  );

  always #10 clk = ~clk;

  // Small aliased SRAM: the handful of addresses used map to distinct rows.
  logic [31:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_word = '0;

  function automatic logic [7:0] midx(input logic [19:0] a);
    return {a[19:16] ^ a[7:4], a[3:0]};
  endfunction

  assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[midx(ram_addr)] : 32'hzzzz_zzzz;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (pre_en) mem[pre_idx] = pre_word;
      else if (!ram_we_n && !ram_ce_n)
        for (int b = 0; b < 4; b++)
          if (!ram_be_n[b]) mem[midx(ram_addr)][8*b +: 8] = ram_data[8*b +: 8];
    end
  end

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   we_low = 0;
  exp_t q[$];
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor / scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset_n) we_low = 0;
    else if (!ram_we_n) we_low++;
    if (dut.drive_en && !ram_oe_n) begin
      bad++;
      $display("FAIL bus_conflict: drive_en=1 oe_n=0 at cycle %0d", cyc);
    end
    if (bus.rsp_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        if (e.wr) check("we_pulse_width", 32'(we_low), 32'(WRITE_WAIT));
      end
      we_low = 0;
    end
  end

  // Presents a request and returns after the accepting edge; req_valid stays high.
  task automatic issue(input logic we, input logic [19:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] exp_rd, output int acc);
    int t = 0;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wd;
    acc = -1;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready=%0b expected 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (!we) last_rd = exp_rd;
    e.rdata = last_rd;
    e.lat   = we ? WRITE_WAIT + 3 : READ_WAIT + 1;
    e.acc   = acc;
    e.wr    = we;
    q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    bus.req_valid = 1'b0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int a0, a1;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;

    // Reset state
    #90;
    check("rst_ce_n", 32'(ram_ce_n), 32'd1);
    check("rst_oe_n", 32'(ram_oe_n), 32'd1);
    check("rst_we_n", 32'(ram_we_n), 32'd1);
    check("rst_be_n", 32'(ram_be_n), 32'hF);
    check("rst_drive", 32'(dut.drive_en), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_addr", 32'(ram_addr), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    check("ready_at_release", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

    // Full-word write then read back
    issue(1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, 32'h0, a0);
    drain();
    issue(1'b0, 20'h00010, 4'hF, 32'h0, 32'hDEADBEEF, a0);
    drain();

    // Byte-enable merge, then an all-disabled write that must change nothing
    issue(1'b1, 20'h00020, 4'hF, 32'h11223344, 32'h0, a0);
    drain();
    issue(1'b1, 20'h00020, 4'b0101, 32'hAABBCCDD, 32'h0, a0);
    drain();
    issue(1'b0, 20'h00020, 4'hF, 32'h0, 32'h11BB33DD, a0);
    drain();
    issue(1'b1, 20'h00020, 4'h0, 32'hFFFFFFFF, 32'h0, a0);
    drain();
    issue(1'b0, 20'h00020, 4'hF, 32'h0, 32'h11BB33DD, a0);
    drain();

    // Back-to-back write then read at the top address, req_valid held high
    issue(1'b1, 20'hFFFFF, 4'hF, 32'h12345678, 32'h0, a0);
    issue(1'b0, 20'hFFFFF, 4'hF, 32'h0, 32'h12345678, a1);
    check("b2b_accept_gap", 32'(a1 - a0), 32'(WRITE_WAIT + 3));
    drain();

    // Reset in the middle of the write pulse
    issue(1'b1, 20'h00010, 4'hF, 32'h0BADF00D, 32'h0, a0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #5;
    check("midwr_we_low", 32'(ram_we_n), 32'd0);
    reset_n = 1'b0;
    q.delete();
    last_rd = '0;
    #1;
    check("midwr_we_n", 32'(ram_we_n), 32'd1);
    check("midwr_ce_n", 32'(ram_ce_n), 32'd1);
    check("midwr_drive", 32'(dut.drive_en), 32'd0);
    check("midwr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(1'b0, 20'h00020, 4'hF, 32'h0, 32'h11BB33DD, a0);
    drain();

    // Preloaded image: little-endian bytes 13 05 00 00 -> word 0x00000513
    begin
      logic [7:0] img [0:3];
      img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h00; img[3] = 8'h00;
      pre_idx  = midx(20'h00000);
      pre_word = {img[3], img[2], img[1], img[0]};
      pre_en   = 1'b1;
      @(negedge clk);
      #1;
      pre_en = 1'b0;
      issue(1'b0, 20'h00000, 4'hF, 32'h0, 32'h00000513, a0);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
